// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
// Carries the memory handshakes, datapath enables/selects and controller status.
interface multicycle_ctrl_if #(
    parameter int RETIRE_W = 32
);
    logic [5:0]          opcode;
    logic                alu_zero;
    logic                imem_ready;
    logic                dmem_ready;

    logic                imem_req;
    logic                ir_we;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic [5:0]          ext_op;
    logic                alu_src_b;
    logic [1:0]          alu_op;
    logic                dmem_req;
    logic                dmem_we;
    logic                reg_we;
    logic                reg_dst;
    logic                wb_sel;
    logic                illegal_op;
    logic [2:0]          state;
    logic [RETIRE_W-1:0] retire_cnt;

    modport master (
        input  opcode, alu_zero, imem_ready, dmem_ready,
        output imem_req, ir_we, pc_we, pc_src, ext_op, alu_src_b, alu_op,
               dmem_req, dmem_we, reg_we, reg_dst, wb_sel, illegal_op,
               state, retire_cnt
    );

    modport slave (
        output opcode, alu_zero, imem_ready, dmem_ready,
        input  imem_req, ir_we, pc_we, pc_src, ext_op, alu_src_b, alu_op,
               dmem_req, dmem_we, reg_we, reg_dst, wb_sel, illegal_op,
               state, retire_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences IF/ID/EX/MEM/WB for one instruction at a time
// and owns every write enable in the core. Ready/zero-qualified enables are Mealy.
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b100001;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_J     = 6'b110001;

    state_t              state_q;
    logic [5:0]          op_q;
    logic [RETIRE_W-1:0] retire_q;

    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [5:0] ext_op;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       reg_dst;
    logic       wb_sel;
    logic       illegal_op;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J);
    endfunction

    // Retirement happens on the exit edge of whichever state completes the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            retire_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_IF;
                S_IF: begin
                    if (bus.imem_ready) begin
                        state_q <= S_ID;
                    end
                end
                S_ID: begin
                    op_q    <= bus.opcode;
                    state_q <= is_legal(bus.opcode) ? S_EX : S_IF;
                end
                S_EX: begin
                    case (op_q)
                        OP_RTYPE: state_q <= S_WB;
                        OP_LW,
                        OP_SW:    state_q <= S_MEM;
                        OP_BEQ,
                        OP_J: begin
                            state_q  <= S_IF;
                            retire_q <= retire_q + 1'b1;
                        end
                        default:  state_q <= S_IDLE;
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        if (op_q == OP_SW) begin
                            state_q  <= S_IF;
                            retire_q <= retire_q + 1'b1;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    state_q  <= S_IF;
                    retire_q <= retire_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode from state and latched opcode; reset clears state so outputs drop at once.
    always_comb begin
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        ext_op     = 6'd0;
        alu_src_b  = 1'b0;
        alu_op     = 2'd0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        wb_sel     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_ID: illegal_op = !is_legal(bus.opcode);
            S_EX: begin
                ext_op = op_q;
                case (op_q)
                    OP_RTYPE: alu_op = 2'd2;
                    OP_LW,
                    OP_SW:    alu_src_b = 1'b1;
                    OP_BEQ: begin
                        alu_op = 2'd1;
                        if (bus.alu_zero) begin
                            pc_we  = 1'b1;
                            pc_src = 2'd1;
                        end
                    end
                    OP_J: begin
                        pc_we  = 1'b1;
                        pc_src = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ext_op    = op_q;
                alu_src_b = 1'b1;
                dmem_req  = 1'b1;
                dmem_we   = (op_q == OP_SW);
            end
            S_WB: begin
                ext_op  = op_q;
                reg_we  = 1'b1;
                reg_dst = (op_q == OP_RTYPE);
                wb_sel  = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign bus.imem_req   = imem_req;
    assign bus.ir_we      = ir_we;
    assign bus.pc_we      = pc_we;
    assign bus.pc_src     = pc_src;
    assign bus.ext_op     = ext_op;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.reg_we     = reg_we;
    assign bus.reg_dst    = reg_dst;
    assign bus.wb_sel     = wb_sel;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = state_q;
    assign bus.retire_cnt = retire_q;

    a_ir_we_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        ir_we |-> imem_req);
    a_store_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        dmem_we |-> dmem_req);
    a_illegal_only_id: assert property (@(posedge clk) disable iff (!rst_n)
        illegal_op |-> (state_q == S_ID));

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the lab CPU datapath. Sequences one instruction at a time through fetch, decode, execute, memory and write-back, with ready handshakes on instruction and data memory. Drives the immediate extender's opcode select, PC source/write, ALU operand and op selects, memory strobes and register-file write. Sits beside the datapath and owns every write enable in the core.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock domain; asynchronous assert, active-low
opcode  in  6  IR[31:26], valid from ID onward
alu_zero  in  1  ALU zero flag, valid in EX
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  instruction register write
pc_we  out  1  PC write
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target (both from extender)
ext_op  out  6  opcode forwarded to extender (latched op_q)
alu_src_b  out  1  0=register, 1=extended immediate
alu_op  out  2  0=ADD, 1=SUB, 2=funct field
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
reg_we  out  1  register-file write
reg_dst  out  1  1=rd (R-type), 0=rt
wb_sel  out  1  0=ALU result, 1=memory data
illegal_op  out  1  one-cycle pulse on undecodable opcode
state  out  3  current state encoding
retire_cnt  out  RETIRE_W  instructions completed since reset

Behaviour:
- Opcodes: RTYPE=000000, LW=100000, SW=100001, BEQ=110000, J=110001; all others illegal.
- States: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5. Values 6, 7 -> IDLE on the next clock.
- Reset (rst_n low, any time, incl. mid-access): state=IDLE, op_q=0, retire_cnt=0, all outputs 0. In-flight memory requests are dropped immediately. No handshake completion is owed.
- Outputs are decoded from state and op_q. Enables qualified by a ready or alu_zero are Mealy, valid in the same cycle. Unlisted outputs are 0 in every state.
- IDLE: all outputs 0; next state IF unconditionally (one cycle after reset release).
- IF: imem_req=1. Stay while imem_ready=0. On imem_ready=1: ir_we=1, pc_we=1, pc_src=0; next state ID.
- ID: op_q<=opcode at end of cycle.
  - Legal opcode -> EX.
  - Illegal opcode -> IF, illegal_op=1 this cycle, retire_cnt unchanged.
- EX: ext_op=op_q.
  - RTYPE: alu_src_b=0, alu_op=2 -> WB.
  - LW/SW: alu_src_b=1, alu_op=0 -> MEM.
  - BEQ: alu_src_b=0, alu_op=1. If alu_zero=1: pc_we=1, pc_src=1. Next state IF; retire.
  - J: pc_we=1, pc_src=2. Next state IF; retire.
- MEM: ext_op=op_q, alu_src_b=1, alu_op=0 (address held), dmem_req=1, dmem_we=(op_q==SW).
  - Stay while dmem_ready=0.
  - On dmem_ready: LW -> WB; SW -> IF and retire.
- WB: reg_we=1. reg_dst=(op_q==RTYPE). wb_sel=(op_q==LW). Next state IF; retire.
- Retire: retire_cnt increments by 1 on the exit edge of the completing state. Wraps all-ones -> 0.
- Latency with zero-wait memories (ready high on first request cycle), IF entry to next IF entry:
  - RTYPE=4, LW=5, SW=4, BEQ=3, J=3, illegal=2 cycles.
- ext_op changes only at ID exit, so the extender output is stable through EX/MEM/WB.
- imem_ready is ignored outside IF; dmem_ready is ignored outside MEM.

Test Plan:
- Reset then RTYPE, imem_ready and dmem_ready tied 1 -> IDLE, IF, ID, EX, WB. reg_we=1 and reg_dst=1 in WB only. retire_cnt=1 after 5 cycles.
- LW with dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0. Then WB with wb_sel=1, reg_we=1. retire_cnt +1.
- SW -> MEM with dmem_we=1, exits to IF on dmem_ready, reg_we never asserted.
- BEQ: alu_zero=1 -> EX pc_we=1, pc_src=1. alu_zero=0 -> pc_we=0 in EX. Both retire in 3 cycles. J -> pc_src=2, pc_we=1 in EX.
- Opcode 111111 -> illegal_op pulses for 1 cycle in ID, return to IF, retire_cnt unchanged. RETIRE_W=4 with 16 retires -> retire_cnt wraps to 0.
- rst_n low for 1 cycle during MEM of SW -> dmem_req and dmem_we drop asynchronously, state=IDLE, retire_cnt=0. After release, IF on the second clock.
